// File: rtl/ray_unit_scheduler.sv
// Frame-level pixel dispatcher: hands raster-order pixels to a pool of ray cores
// and funnels their results into a frame buffer through a round-robin writeback.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

module ray_unit_scheduler #(
  parameter int NUM_CORES      = 4,
  parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int H_BITS         = `H_BITS,
  parameter int V_BITS         = `V_BITS,
  parameter int ADDR_BITS      = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT),
  parameter int VEC3_BITS      = 48
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic [VEC3_BITS-1:0]          ray_origin_in,
  input  logic [VEC3_BITS-1:0]          cam_forward_in,
  input  logic [2:0]                    fractal_sel_in,
  output logic [NUM_CORES-1:0]          core_valid_out,
  output logic [H_BITS-1:0]             core_hcount_out,
  output logic [V_BITS-1:0]             core_vcount_out,
  output logic [VEC3_BITS-1:0]          core_ray_origin_out,
  output logic [VEC3_BITS-1:0]          core_ray_direction_out,
  output logic [2:0]                    core_fractal_sel_out,
  input  logic [NUM_CORES-1:0]          core_ready_in,
  input  logic [NUM_CORES*H_BITS-1:0]   core_hcount_in,
  input  logic [NUM_CORES*V_BITS-1:0]   core_vcount_in,
  input  logic [NUM_CORES*4-1:0]        core_color_in,
  output logic                          fb_we_out,
  output logic [ADDR_BITS-1:0]          fb_addr_out,
  output logic [3:0]                    fb_data_out,
  output logic                          busy_out,
  output logic                          frame_done_out
);

  localparam int PTR_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // state     | meaning
  // SCH_IDLE  | waiting for start_in, camera latched on start
  // SCH_RUN   | dispatching pixels in raster order
  // SCH_DRAIN | last pixel issued, waiting for in-flight and pending results
  typedef enum logic [1:0] {SCH_IDLE, SCH_RUN, SCH_DRAIN} sch_state_t;
  sch_state_t r_state;

  logic [NUM_CORES-1:0] r_in_flight, r_seen_busy, r_pending;
  logic [H_BITS-1:0]    r_pix_h;
  logic [V_BITS-1:0]    r_pix_v;
  logic [PTR_BITS-1:0]  r_rr_ptr;
  logic [H_BITS-1:0]    r_res_h [NUM_CORES];
  logic [V_BITS-1:0]    r_res_v [NUM_CORES];
  logic [3:0]           r_res_c [NUM_CORES];

  logic [NUM_CORES-1:0] r_core_valid;
  logic [H_BITS-1:0]    r_core_h;
  logic [V_BITS-1:0]    r_core_v;
  logic [VEC3_BITS-1:0] r_origin, r_dir;
  logic [2:0]           r_sel;
  logic                 r_fb_we, r_frame_done;
  logic [ADDR_BITS-1:0] r_fb_addr;
  logic [3:0]           r_fb_data;

  logic [NUM_CORES-1:0] w_eligible, w_done, w_disp_onehot, w_win_onehot;
  logic                 w_disp_valid, w_win_valid;
  logic [PTR_BITS-1:0]  w_win_idx, w_cand, w_ptr_next;
  logic [ADDR_BITS-1:0] w_fb_addr;
  int                   w_idx;

  assign w_eligible = core_ready_in & ~r_in_flight & ~r_pending;
  assign w_done     = r_in_flight & r_seen_busy & core_ready_in;

  always_comb begin
    w_disp_onehot = '0;
    w_disp_valid  = 1'b0;
    if (r_state == SCH_RUN) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!w_disp_valid && w_eligible[i]) begin
          w_disp_onehot[i] = 1'b1;
          w_disp_valid     = 1'b1;
        end
      end
    end
  end

  // Round-robin search starts at the pointer and wraps around the core pool.
  always_comb begin
    w_win_valid  = 1'b0;
    w_win_idx    = '0;
    w_win_onehot = '0;
    w_idx        = 0;
    w_cand       = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_CORES) w_idx = w_idx - NUM_CORES;
      w_cand = PTR_BITS'(w_idx);
      if (!w_win_valid && r_pending[w_cand]) begin
        w_win_valid          = 1'b1;
        w_win_idx            = w_cand;
        w_win_onehot[w_cand] = 1'b1;
      end
    end
  end

  assign w_ptr_next = (w_win_idx == PTR_BITS'(NUM_CORES-1)) ? '0 : w_win_idx + 1'b1;
  assign w_fb_addr  = ADDR_BITS'(r_res_v[w_win_idx]) * ADDR_BITS'(DISPLAY_WIDTH)
                    + ADDR_BITS'(r_res_h[w_win_idx]);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= SCH_IDLE;
      r_in_flight  <= '0;
      r_seen_busy  <= '0;
      r_pending    <= '0;
      r_pix_h      <= '0;
      r_pix_v      <= '0;
      r_rr_ptr     <= '0;
      r_core_valid <= '0;
      r_core_h     <= '0;
      r_core_v     <= '0;
      r_origin     <= '0;
      r_dir        <= '0;
      r_sel        <= '0;
      r_fb_we      <= 1'b0;
      r_fb_addr    <= '0;
      r_fb_data    <= '0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_res_h[i] <= '0;
        r_res_v[i] <= '0;
        r_res_c[i] <= '0;
      end
    end else begin
      r_core_valid <= '0;
      r_fb_we      <= 1'b0;
      r_frame_done <= 1'b0;

      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_done[i]) begin
          r_res_h[i] <= core_hcount_in[i*H_BITS +: H_BITS];
          r_res_v[i] <= core_vcount_in[i*V_BITS +: V_BITS];
          r_res_c[i] <= core_color_in[i*4 +: 4];
        end
      end
      r_seen_busy <= (r_seen_busy | (r_in_flight & ~core_ready_in)) & ~w_disp_onehot;
      r_in_flight <= (r_in_flight & ~w_done) | w_disp_onehot;
      r_pending   <= (r_pending | w_done) & ~w_win_onehot;

      if (w_win_valid) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= w_fb_addr;
        r_fb_data <= r_res_c[w_win_idx];
        r_rr_ptr  <= w_ptr_next;
      end

      case (r_state)
        SCH_IDLE: begin
          if (start_in) begin
            r_origin <= ray_origin_in;
            r_dir    <= cam_forward_in;
            r_sel    <= fractal_sel_in;
            r_pix_h  <= '0;
            r_pix_v  <= '0;
            r_state  <= SCH_RUN;
          end
        end
        SCH_RUN: begin
          if (w_disp_valid) begin
            r_core_valid <= w_disp_onehot;
            r_core_h     <= r_pix_h;
            r_core_v     <= r_pix_v;
            if (r_pix_h == H_BITS'(DISPLAY_WIDTH-1)) begin
              r_pix_h <= '0;
              if (r_pix_v == V_BITS'(DISPLAY_HEIGHT-1)) begin
                r_pix_v <= '0;
                r_state <= SCH_DRAIN;
              end else begin
                r_pix_v <= r_pix_v + 1'b1;
              end
            end else begin
              r_pix_h <= r_pix_h + 1'b1;
            end
          end
        end
        SCH_DRAIN: begin
          // Write selected last cycle is on the bus now, so done lands right after it.
          if (r_in_flight == '0 && r_pending == '0) begin
            r_frame_done <= 1'b1;
            r_state      <= SCH_IDLE;
          end
        end
        default: r_state <= SCH_IDLE;
      endcase
    end
  end

  assign core_valid_out         = r_core_valid;
  assign core_hcount_out        = r_core_h;
  assign core_vcount_out        = r_core_v;
  assign core_ray_origin_out    = r_origin;
  assign core_ray_direction_out = r_dir;
  assign core_fractal_sel_out   = r_sel;
  assign fb_we_out              = r_fb_we;
  assign fb_addr_out            = r_fb_addr;
  assign fb_data_out            = r_fb_data;
  assign busy_out               = (r_state != SCH_IDLE);
  assign frame_done_out         = r_frame_done;

endmodule

// File: doc/ray_unit_scheduler.md
RAY_UNIT_SCHEDULER -- requirements
Module: ray_unit_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_CORES, default 4, number of ray units served; DISPLAY_WIDTH, default `DISPLAY_WIDTH, pixels per line; DISPLAY_HEIGHT, default `DISPLAY_HEIGHT, lines per frame; H_BITS, default `H_BITS, hcount width; V_BITS, default `V_BITS, vcount width; ADDR_BITS, default $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT), frame buffer address width.
REQ-002 The design SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-003 clk_in  input  1  the only clock.
REQ-004 rst_n_in  input  1  asynchronous active-low reset.
REQ-005 start_in  input  1  frame start request.
REQ-006 ray_origin_in  input  vec3  camera position.
REQ-007 cam_forward_in  input  vec3  camera forward vector.
REQ-008 fractal_sel_in  input  3  scene select.
REQ-009 core_valid_out  output  NUM_CORES  one-hot dispatch strobe.
REQ-010 core_hcount_out / core_vcount_out  output  H_BITS / V_BITS  dispatched pixel, broadcast to all cores.
REQ-011 core_ray_origin_out / core_ray_direction_out  output  vec3  latched camera, broadcast to all cores.
REQ-012 core_fractal_sel_out  output  3  latched scene select.
REQ-013 core_ready_in  input  NUM_CORES  per-core ready.
REQ-014 core_hcount_in / core_vcount_in  input  NUM_CORES*H_BITS / NUM_CORES*V_BITS  per-core result coordinates, core i at slice i.
REQ-015 core_color_in  input  NUM_CORES*4  per-core result colour.
REQ-016 fb_we_out  output  1  frame buffer write strobe.
REQ-017 fb_addr_out  output  ADDR_BITS  write address.
REQ-018 fb_data_out  output  4  write data.
REQ-019 busy_out  output  1  high whenever state != SCH_IDLE.
REQ-020 frame_done_out  output  1  one-cycle pulse at frame completion.

Function
REQ-021 The FSM SHALL have three states: SCH_IDLE, SCH_RUN and SCH_DRAIN.
REQ-022 In SCH_IDLE, when start_in=1, the block SHALL latch ray_origin_in, cam_forward_in and fractal_sel_in, set the pixel counter to (0,0) and go to SCH_RUN.
REQ-023 start_in SHALL be ignored in SCH_RUN and SCH_DRAIN.
REQ-024 Each core SHALL have three flags: in_flight, seen_busy and pending.
REQ-025 A core SHALL be eligible when core_ready_in=1, in_flight=0 and pending=0.
REQ-026 In SCH_RUN, at most one dispatch SHALL occur per cycle, to the lowest-index eligible core.
REQ-027 On a dispatch to core i: core_valid_out SHALL be one-hot bit i for exactly one cycle; the coordinate and camera outputs SHALL be valid in that cycle; in_flight[i] SHALL be set and seen_busy[i] cleared.
REQ-028 The pixel counter SHALL advance in raster order, hcount first, wrapping at DISPLAY_WIDTH-1 and incrementing vcount.
REQ-029 Dispatch of pixel (DISPLAY_WIDTH-1, DISPLAY_HEIGHT-1) SHALL move the FSM to SCH_DRAIN.
REQ-030 seen_busy[i] SHALL set when in_flight[i]=1 and core_ready_in[i]=0.
REQ-031 Completion of core i SHALL be defined as in_flight[i]=1, seen_busy[i]=1 and core_ready_in[i]=1.
REQ-032 On completion, the block SHALL capture core i's hcount, vcount and colour into its result register, set pending[i] and clear in_flight[i].
REQ-033 Writeback SHALL perform at most one write per cycle, chosen by a round-robin arbiter over the pending flags; the pointer SHALL advance to winner+1 mod NUM_CORES.
REQ-034 One cycle after a winner is selected, fb_we_out SHALL be 1, fb_addr_out SHALL equal vcount*DISPLAY_WIDTH + hcount, and fb_data_out SHALL equal the colour; pending of the winner SHALL clear in the selection cycle.
REQ-035 If a completion and a writeback of the same core fall in the same cycle, this SHALL be impossible by construction, because pending blocks re-dispatch.
REQ-036 If completion and dispatch are eligible in the same cycle for different cores, both SHALL proceed.
REQ-037 In SCH_DRAIN, when all in_flight=0, all pending=0 and no write is outstanding, the block SHALL pulse frame_done_out for one cycle and return to SCH_IDLE.
REQ-038 frame_done_out SHALL assert in the cycle after the last fb_we_out.
REQ-039 A core that never becomes ready SHALL stall the frame indefinitely; no timeout is required.

Reset
REQ-040 While rst_n_in=0, the block SHALL asynchronously force: state SCH_IDLE; all flags 0; pixel counter 0; round-robin pointer 0; core_valid_out 0; fb_we_out 0; frame_done_out 0; busy_out 0; data outputs 0.
REQ-041 Reset mid-frame SHALL abandon the frame with no further writes.
REQ-042 Cores are reset separately.

Verification
REQ-043 NUM_CORES=1, 2x2 display, core with 3-cycle latency, colour=hcount+vcount: the bench SHALL see four writes to addresses 0,1,2,3 with data 0,1,1,2, then frame_done_out one cycle after the last write, and busy_out low afterwards.
REQ-044 NUM_CORES=4, all ready at start: the bench SHALL see dispatches on consecutive cycles to cores 0,1,2,3 with pixels (0,0),(1,0),(2,0),(3,0).
REQ-045 Cores 1 and 3 complete in the same cycle with the pointer at 2: the bench SHALL see core 3 written first, then core 1 on the next cycle.
REQ-046 A core that completes but whose result is still pending SHALL NOT receive a new dispatch until fb_we_out has been issued for it.
REQ-047 start_in pulsed during SCH_RUN SHALL have no effect, and the camera outputs SHALL hold their latched values.
REQ-048 Asserting rst_n_in=0 mid-frame SHALL take all outputs to 0 immediately, without waiting for a clock edge; after release, a new start SHALL render a full frame correctly.
